// File: rtl/bit_dmem.sv
// Bit-addressable data memory for the bit-logic CPU core plus a word-wide host port.
// Define BIT_DMEM_PARITY_EN to store and check an even-parity bit per RAM word.
module bit_dmem #(
    parameter int DA_W   = 12,
    parameter int WORD_W = 8,
    parameter int BIT_W  = 3,
    parameter int HA_W   = 9,
    parameter int RD_WS  = 1
) (
    input  logic              CLK,
    input  logic              CLR_N,
    input  logic [DA_W-1:0]   D_A,
    input  logic              D_OE,
    input  logic              D_WE,
    input  logic              D_O,
    output logic              D_I,
    output logic              D_RDY,
    input  logic [HA_W-1:0]   H_A,
    input  logic [WORD_W-1:0] H_DI,
    input  logic              H_RD,
    input  logic              H_WR,
    output logic [WORD_W-1:0] H_DO,
    output logic              H_ACK,
    output logic              H_BUSY,
    output logic              PAR_ERR
);

    typedef enum logic [2:0] {IDLE, RWAIT, WRITE, ACK, HWAIT, HACK} state_e;

    localparam int         DEPTH   = 2**HA_W;
    localparam logic [2:0] WS_INIT = 3'((RD_WS > 0) ? RD_WS - 1 : 0);

    logic [WORD_W-1:0] mem [DEPTH];

    state_e            state_q;
    logic              wr_q;
    logic [HA_W-1:0]   waddr_q;
    logic [BIT_W-1:0]  bsel_q;
    logic              dbit_q;
    logic [WORD_W-1:0] rd_q;
    logic [2:0]        ws_q;
    logic              hp_q;
    logic              hwr_q;
    logic [HA_W-1:0]   ha_q;
    logic [WORD_W-1:0] hdi_q;
    logic              busy_q;
    logic              d_i_q;
    logic              d_rdy_q;
    logic [WORD_W-1:0] h_do_q;
    logic              h_ack_q;

    logic              strobe_acc;
    logic              host_go;
    logic              cpu_go;
    logic [HA_W-1:0]   ram_ra;
    logic [HA_W-1:0]   ram_wa;
    logic [WORD_W-1:0] rdata_c;
    logic [WORD_W-1:0] merged;
    logic [WORD_W-1:0] ram_wd;
    logic              ram_we;

    // A strobe seen while idle also holds off the CPU so the host is served first.
    assign strobe_acc = (H_RD | H_WR) & ~busy_q;
    assign host_go    = (state_q == IDLE) & hp_q;
    assign cpu_go     = (state_q == IDLE) & ~hp_q & ~strobe_acc & (D_WE | D_OE);

    always_comb begin
        // NOTE: default assignment first so no path leaves ram_ra unassigned (no latch).
        ram_ra = waddr_q;
        if (state_q == IDLE) begin
            ram_ra = hp_q ? ha_q : D_A[DA_W-1:BIT_W];
        end
    end

    assign rdata_c = mem[ram_ra];

    always_comb begin
        merged         = rd_q;
        merged[bsel_q] = dbit_q;
        ram_wd         = (state_q == WRITE) ? merged : hdi_q;
    end

    assign ram_we = (state_q == WRITE) | (host_go & hwr_q);
    assign ram_wa = (state_q == WRITE) ? waddr_q : ha_q;

    // NOTE: RAM array has no reset; contents survive CLR_N and writes are gated by FSM state.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            mem[ram_wa] <= ram_wd;
        end
    end

`ifdef BIT_DMEM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_err_q;
    logic par_bad;

    assign par_bad = ^{rdata_c, par_mem[ram_ra]};

    always_ff @(posedge CLK) begin
        if (ram_we) begin
            par_mem[ram_wa] <= ^ram_wd;
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            par_err_q <= 1'b0;
        end else if ((cpu_go | (host_go & ~hwr_q)) & par_bad) begin
            par_err_q <= 1'b1;
        end
    end

    assign PAR_ERR = par_err_q;
`else
    assign PAR_ERR = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            waddr_q <= '0;
            bsel_q  <= '0;
            dbit_q  <= 1'b0;
            rd_q    <= '0;
            ws_q    <= '0;
            hp_q    <= 1'b0;
            hwr_q   <= 1'b0;
            ha_q    <= '0;
            hdi_q   <= '0;
            busy_q  <= 1'b0;
            d_i_q   <= 1'b0;
            d_rdy_q <= 1'b0;
            h_do_q  <= '0;
            h_ack_q <= 1'b0;
        end else begin
            if (strobe_acc) begin
                hp_q   <= 1'b1;
                hwr_q  <= H_WR;
                ha_q   <= H_A;
                hdi_q  <= H_DI;
                busy_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (host_go) begin
                        hp_q <= 1'b0;
                        if (hwr_q) begin
                            h_ack_q <= 1'b1;
                            state_q <= HACK;
                        end else begin
                            rd_q <= rdata_c;
                            if (RD_WS == 0) begin
                                h_do_q  <= rdata_c;
                                h_ack_q <= 1'b1;
                                state_q <= HACK;
                            end else begin
                                ws_q    <= WS_INIT;
                                state_q <= HWAIT;
                            end
                        end
                    end else if (cpu_go) begin
                        wr_q    <= D_WE;
                        waddr_q <= D_A[DA_W-1:BIT_W];
                        bsel_q  <= D_A[BIT_W-1:0];
                        dbit_q  <= D_O;
                        rd_q    <= rdata_c;
                        if (RD_WS != 0) begin
                            ws_q    <= WS_INIT;
                            state_q <= RWAIT;
                        end else if (D_WE) begin
                            state_q <= WRITE;
                        end else begin
                            d_i_q   <= rdata_c[D_A[BIT_W-1:0]];
                            d_rdy_q <= 1'b1;
                            state_q <= ACK;
                        end
                    end
                end
                RWAIT: begin
                    if (ws_q != 3'd0) begin
                        ws_q <= ws_q - 3'd1;
                    end else if (wr_q) begin
                        state_q <= WRITE;
                    end else if (D_OE) begin
                        d_i_q   <= rd_q[bsel_q];
                        d_rdy_q <= 1'b1;
                        state_q <= ACK;
                    end else begin
                        // Read withdrawn by a pipe flush: drop it without touching D_I.
                        state_q <= IDLE;
                    end
                end
                WRITE: begin
                    d_rdy_q <= 1'b1;
                    state_q <= ACK;
                end
                ACK: begin
                    d_rdy_q <= 1'b0;
                    state_q <= IDLE;
                end
                HWAIT: begin
                    if (ws_q != 3'd0) begin
                        ws_q <= ws_q - 3'd1;
                    end else begin
                        h_do_q  <= rd_q;
                        h_ack_q <= 1'b1;
                        state_q <= HACK;
                    end
                end
                HACK: begin
                    h_ack_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A read whose D_OE has fallen by the ACK cycle never signals ready.
    assign D_RDY  = d_rdy_q & (wr_q | D_OE);
    assign D_I    = d_i_q;
    assign H_DO   = h_do_q;
    assign H_ACK  = h_ack_q;
    assign H_BUSY = busy_q;

endmodule

// File: tb/tb_bit_dmem.sv
// Scoreboard bench for bit_dmem: DUT 0 runs with RD_WS=0, DUT 1 with RD_WS=2.
module tb_bit_dmem;

    localparam int WS0 = 0;
    localparam int WS1 = 2;

    typedef struct {
        bit         is_host;
        bit         chk;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n   [2];
    logic [11:0] d_a     [2];
    logic        d_oe    [2];
    logic        d_we    [2];
    logic        d_o     [2];
    logic        d_i     [2];
    logic        d_rdy   [2];
    logic [8:0]  h_a     [2];
    logic [7:0]  h_di    [2];
    logic        h_rd    [2];
    logic        h_wr    [2];
    logic [7:0]  h_do    [2];
    logic        h_ack   [2];
    logic        h_busy  [2];
    logic        par_err [2];

    int   checks   = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    bit_dmem #(.DA_W(12), .WORD_W(8), .BIT_W(3), .HA_W(9), .RD_WS(WS0)) u_dut0 (
        .CLK(clk), .CLR_N(rst_n[0]), .D_A(d_a[0]), .D_OE(d_oe[0]), .D_WE(d_we[0]),
        .D_O(d_o[0]), .D_I(d_i[0]), .D_RDY(d_rdy[0]), .H_A(h_a[0]), .H_DI(h_di[0]),
        .H_RD(h_rd[0]), .H_WR(h_wr[0]), .H_DO(h_do[0]), .H_ACK(h_ack[0]),
        .H_BUSY(h_busy[0]), .PAR_ERR(par_err[0])
    );

    bit_dmem #(.DA_W(12), .WORD_W(8), .BIT_W(3), .HA_W(9), .RD_WS(WS1)) u_dut1 (
        .CLK(clk), .CLR_N(rst_n[1]), .D_A(d_a[1]), .D_OE(d_oe[1]), .D_WE(d_we[1]),
        .D_O(d_o[1]), .D_I(d_i[1]), .D_RDY(d_rdy[1]), .H_A(h_a[1]), .H_DI(h_di[1]),
        .H_RD(h_rd[1]), .H_WR(h_wr[1]), .H_DO(h_do[1]), .H_ACK(h_ack[1]),
        .H_BUSY(h_busy[1]), .PAR_ERR(par_err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int ws_of(input int s);
        return (s == 0) ? WS0 : WS1;
    endfunction

    task automatic push(input int s, input exp_t e);
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor: every D_RDY / H_ACK pulse must match the oldest expected event.
    task automatic mon(input int s);
        exp_t e;
        int   depth;
        if (d_rdy[s] === 1'b1 || h_ack[s] === 1'b1) begin
            depth = (s == 0) ? q0.size() : q1.size();
            if (depth == 0) begin
                check($sformatf("unexpected_event_dut%0d", s), {30'd0, d_rdy[s], h_ack[s]}, 32'd0);
            end else begin
                e = (s == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("event_kind_dut%0d", s), {31'd0, h_ack[s]}, {31'd0, e.is_host});
                if (e.chk) begin
                    if (e.is_host) check($sformatf("h_do_dut%0d", s), {24'd0, h_do[s]}, {24'd0, e.data});
                    else           check($sformatf("d_i_dut%0d", s), {31'd0, d_i[s]}, {24'd0, e.data});
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic cpu_op(input int s, input bit we, input logic [11:0] a, input bit dout,
                          input bit exp_bit);
        exp_t e;
        int   lows;
        e.is_host = 1'b0;
        e.chk     = !we;
        e.data    = {7'd0, exp_bit};
        push(s, e);
        d_a[s]  = a;
        d_we[s] = we;
        d_oe[s] = !we;
        d_o[s]  = dout;
        lows    = 0;
        while (lows <= 40) begin
            @(negedge clk);
            if (d_rdy[s] === 1'b1) break;
            lows++;
        end
        check($sformatf("cpu_latency_dut%0d_%s_%03h", s, we ? "wr" : "rd", a),
              lows, (we ? 2 : 1) + ws_of(s));
        @(posedge clk); #1;
        d_we[s] = 1'b0;
        d_oe[s] = 1'b0;
    endtask

    task automatic host_op(input int s, input bit wr, input logic [8:0] a, input logic [7:0] wd,
                           input logic [7:0] exp_rd);
        exp_t e;
        int   lows;
        e.is_host = 1'b1;
        e.chk     = !wr;
        e.data    = exp_rd;
        push(s, e);
        h_a[s]  = a;
        h_di[s] = wd;
        h_wr[s] = wr;
        h_rd[s] = !wr;
        @(negedge clk);
        lows = 1;
        @(posedge clk); #1;
        h_wr[s] = 1'b0;
        h_rd[s] = 1'b0;
        while (lows <= 40) begin
            @(negedge clk);
            if (h_ack[s] === 1'b1) break;
            lows++;
        end
        check($sformatf("host_latency_dut%0d_%s_%03h", s, wr ? "wr" : "rd", a),
              lows, wr ? 2 : 2 + ws_of(s));
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input int s, input string tag);
        check($sformatf("%s_d_i_dut%0d", tag, s),     {31'd0, d_i[s]},     32'd0);
        check($sformatf("%s_d_rdy_dut%0d", tag, s),   {31'd0, d_rdy[s]},   32'd0);
        check($sformatf("%s_h_do_dut%0d", tag, s),    {24'd0, h_do[s]},    32'd0);
        check($sformatf("%s_h_ack_dut%0d", tag, s),   {31'd0, h_ack[s]},   32'd0);
        check($sformatf("%s_h_busy_dut%0d", tag, s),  {31'd0, h_busy[s]},  32'd0);
        check($sformatf("%s_par_err_dut%0d", tag, s), {31'd0, par_err[s]}, 32'd0);
    endtask

    initial begin
        exp_t e;
        int   lows;

        for (int s = 0; s < 2; s++) begin
            rst_n[s] = 1'b0;
            d_a[s]   = '0;
            d_oe[s]  = 1'b0;
            d_we[s]  = 1'b0;
            d_o[s]   = 1'b0;
            h_a[s]   = '0;
            h_di[s]  = '0;
            h_rd[s]  = 1'b0;
            h_wr[s]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_zero(0, "reset");
        check_zero(1, "reset");
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(posedge clk); #1;

        // RD_WS=0: host load, bit reads, RMW write, host readback.
        host_op(0, 1'b1, 9'h012, 8'h05, 8'h00);
        cpu_op(0, 1'b0, 12'h090, 1'b0, 1'b1);
        cpu_op(0, 1'b0, 12'h091, 1'b0, 1'b0);
        cpu_op(0, 1'b1, 12'h093, 1'b1, 1'b0);
        host_op(0, 1'b0, 9'h012, 8'h00, 8'h0D);

        // Host write and CPU read in the same cycle: host first, CPU sees new data.
        e.is_host = 1'b1; e.chk = 1'b0; e.data = 8'h00;
        push(0, e);
        e.is_host = 1'b0; e.chk = 1'b1; e.data = 8'h01;
        push(0, e);
        h_a[0]  = 9'h012;
        h_di[0] = 8'hFF;
        h_wr[0] = 1'b1;
        d_a[0]  = 12'h094;
        d_oe[0] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        h_wr[0] = 1'b0;
        h_rd[0] = 1'b1;
        h_a[0]  = 9'h000;
        @(negedge clk);
        check("busy_during_host", {31'd0, h_busy[0]}, 32'd1);
        @(posedge clk); #1;
        h_rd[0] = 1'b0;
        lows = 2;
        while (lows <= 40) begin
            @(negedge clk);
            if (d_rdy[0] === 1'b1) break;
            lows++;
        end
        check("concurrent_rdy_cycle", lows, 4);
        @(posedge clk); #1;
        d_oe[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_cleared", {31'd0, h_busy[0]}, 32'd0);

        // Clear a bit, then boundary words 0x1FF and 0x000.
        cpu_op(0, 1'b1, 12'h094, 1'b0, 1'b0);
        host_op(0, 1'b0, 9'h012, 8'h00, 8'hEF);
        host_op(0, 1'b1, 9'h1FF, 8'h00, 8'h00);
        cpu_op(0, 1'b1, 12'hFFF, 1'b1, 1'b0);
        host_op(0, 1'b0, 9'h1FF, 8'h00, 8'h80);
        cpu_op(0, 1'b0, 12'hFFF, 1'b0, 1'b1);
        cpu_op(0, 1'b0, 12'hFF8, 1'b0, 1'b0);
        host_op(0, 1'b1, 9'h000, 8'h01, 8'h00);
        cpu_op(0, 1'b0, 12'h000, 1'b0, 1'b1);

`ifdef BIT_DMEM_PARITY_EN
        check("par_err_before", {31'd0, par_err[0]}, 32'd0);
        u_dut0.par_mem[9'h012] = ~u_dut0.par_mem[9'h012];
        cpu_op(0, 1'b0, 12'h090, 1'b0, 1'b1);
        check("par_err_set", {31'd0, par_err[0]}, 32'd1);
        host_op(0, 1'b1, 9'h012, 8'hEF, 8'h00);
        cpu_op(0, 1'b0, 12'h091, 1'b0, 1'b1);
        check("par_err_sticky", {31'd0, par_err[0]}, 32'd1);
        rst_n[0] = 1'b0;
        #1;
        check("par_err_cleared", {31'd0, par_err[0]}, 32'd0);
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        @(posedge clk); #1;
`else
        check("par_err_tied_dut0", {31'd0, par_err[0]}, 32'd0);
`endif

        // RD_WS=2: latency, read abort, reset during an RMW.
        host_op(1, 1'b1, 9'h012, 8'h05, 8'h00);
        host_op(1, 1'b0, 9'h012, 8'h00, 8'h05);
        cpu_op(1, 1'b0, 12'h090, 1'b0, 1'b1);

        d_a[1]  = 12'h091;
        d_oe[1] = 1'b1;
        @(posedge clk); #1;
        d_oe[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_d_i_held", {31'd0, d_i[1]}, 32'd1);
        check("abort_no_rdy", {31'd0, d_rdy[1]}, 32'd0);
        cpu_op(1, 1'b0, 12'h093, 1'b0, 1'b0);
        cpu_op(1, 1'b0, 12'h090, 1'b0, 1'b1);

        d_a[1]  = 12'h093;
        d_o[1]  = 1'b1;
        d_we[1] = 1'b1;
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        #1;
        check_zero(1, "midrmw");
        d_we[1] = 1'b0;
        d_o[1]  = 1'b0;
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        @(posedge clk); #1;
        host_op(1, 1'b0, 9'h012, 8'h00, 8'h05);
        check("par_err_dut1", {31'd0, par_err[1]}, 32'd0);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", q0.size() + q1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
